// File: rtl/flit_activity_sink.sv
// Receive end of the flit injection link used for energy characterization.
// It accepts flits from the packet injector whenever it is not stalled. Inside a
// start/stop measurement window it counts flits, packets, length errors, idle cycles
// and bit toggles (the Hamming distance between consecutive accepted flits).
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flit_valid/data    incoming flit; data[N-1:0] = operand 1, data[2N-1:N] = operand 2
//   flit_last          flit is the tail of its packet
//   flit_ready         combinational, equal to ~sink_stall
//   sink_stall         test-only backpressure
//   meas_start/stop    open / close the measurement window (pulses)
//   stat_valid         window closed, statistics frozen
//   flit_cnt .. last_pkt_toggles   saturating statistics counters (registered)
module flit_activity_sink #(
    parameter int unsigned N       = 13,
    parameter int unsigned PAYLOAD = 20,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flit_valid,
    input  logic [2*N-1:0]       flit_data,
    input  logic                 flit_last,
    output logic                 flit_ready,
    input  logic                 sink_stall,
    input  logic                 meas_start,
    input  logic                 meas_stop,
    output logic                 stat_valid,
    output logic [CNT_W-1:0]     flit_cnt,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     len_err_cnt,
    output logic [CNT_W-1:0]     idle_cnt,
    output logic [CNT_W-1:0]     toggle_cnt,
    output logic [CNT_W-1:0]     last_pkt_toggles
);

    localparam int unsigned FW = 2 * N;
    localparam int unsigned TW = $clog2(FW + 1);
    localparam int unsigned AW = CNT_W + TW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_PKT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     prev_flit_q;
    logic [CNT_W-1:0]  pkt_len_q, pkt_len_d;
    logic [CNT_W-1:0]  pkt_tog_q, pkt_tog_d;
    logic [CNT_W-1:0]  flit_cnt_d, pkt_cnt_d, len_err_cnt_d, idle_cnt_d;
    logic [CNT_W-1:0]  toggle_cnt_d, last_pkt_toggles_d;
    logic              stat_valid_d;

    logic              accept;
    logic              in_window;
    logic              len_bad;
    logic [TW-1:0]     tog;
    logic [CNT_W:0]    len_plus;

    // Saturating add of a small increment to a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [TW-1:0]    b);
        logic [AW-1:0] sum;
        sum = AW'(a) + AW'(b);
        return (sum > AW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    assign flit_ready = ~sink_stall;
    assign accept     = flit_valid & ~sink_stall;
    assign in_window  = (state_q == ST_GAP) || (state_q == ST_PKT);
    assign tog        = TW'($countones(flit_data ^ prev_flit_q));

    // A saturated length can never be a valid length, so it is always an error.
    assign len_plus   = (CNT_W + 1)'(pkt_len_q) + (CNT_W + 1)'(1);
    assign len_bad    = (&pkt_len_q) || (len_plus != (CNT_W + 1)'(PAYLOAD));

    // Next-state and next-counter logic
    always_comb begin
        state_d            = state_q;
        pkt_len_d          = pkt_len_q;
        pkt_tog_d          = pkt_tog_q;
        flit_cnt_d         = flit_cnt;
        pkt_cnt_d          = pkt_cnt;
        len_err_cnt_d      = len_err_cnt;
        idle_cnt_d         = idle_cnt;
        toggle_cnt_d       = toggle_cnt;
        last_pkt_toggles_d = last_pkt_toggles;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (meas_start) begin
                    state_d            = ST_GAP;
                    pkt_len_d          = '0;
                    pkt_tog_d          = '0;
                    flit_cnt_d         = '0;
                    pkt_cnt_d          = '0;
                    len_err_cnt_d      = '0;
                    idle_cnt_d         = '0;
                    toggle_cnt_d       = '0;
                    last_pkt_toggles_d = '0;
                end
            end
            ST_GAP: if (accept && !flit_last) state_d = ST_PKT;
            ST_PKT: if (accept && flit_last)  state_d = ST_GAP;
            default: state_d = ST_IDLE;
        endcase

        // Window accounting; the stop cycle itself is still counted.
        if (in_window) begin
            if (accept) begin
                flit_cnt_d   = sat_add(flit_cnt, TW'(1));
                toggle_cnt_d = sat_add(toggle_cnt, tog);
                if (flit_last) begin
                    pkt_cnt_d          = sat_add(pkt_cnt, TW'(1));
                    last_pkt_toggles_d = sat_add(pkt_tog_q, tog);
                    if (len_bad) len_err_cnt_d = sat_add(len_err_cnt, TW'(1));
                    pkt_len_d          = '0;
                    pkt_tog_d          = '0;
                end else begin
                    pkt_len_d = sat_add(pkt_len_q, TW'(1));
                    pkt_tog_d = sat_add(pkt_tog_q, tog);
                end
            end else begin
                idle_cnt_d = sat_add(idle_cnt, TW'(1));
            end
            if (meas_stop) state_d = ST_DONE;
        end

        stat_valid_d = (state_d == ST_DONE);
    end

    // State and statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            prev_flit_q      <= '0;
            pkt_len_q        <= '0;
            pkt_tog_q        <= '0;
            flit_cnt         <= '0;
            pkt_cnt          <= '0;
            len_err_cnt      <= '0;
            idle_cnt         <= '0;
            toggle_cnt       <= '0;
            last_pkt_toggles <= '0;
            stat_valid       <= 1'b0;
        end else begin
            state_q          <= state_d;
            if (accept) prev_flit_q <= flit_data;
            pkt_len_q        <= pkt_len_d;
            pkt_tog_q        <= pkt_tog_d;
            flit_cnt         <= flit_cnt_d;
            pkt_cnt          <= pkt_cnt_d;
            len_err_cnt      <= len_err_cnt_d;
            idle_cnt         <= idle_cnt_d;
            toggle_cnt       <= toggle_cnt_d;
            last_pkt_toggles <= last_pkt_toggles_d;
            stat_valid       <= stat_valid_d;
        end
    end

endmodule

// File: tb/tb_flit_activity_sink.sv
// Bench for flit_activity_sink: directed scenarios plus random traffic, every cycle
// compared against a window/packet accounting model kept here.
module tb_flit_activity_sink;

    localparam int unsigned N  = 13;
    localparam int unsigned FW = 2 * N;
    localparam int unsigned PL = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flit_valid, flit_last, sink_stall, meas_start, meas_stop;
    logic [FW-1:0] flit_data;

    logic          flit_ready, stat_valid;
    logic [31:0]   flit_cnt, pkt_cnt, len_err_cnt, idle_cnt, toggle_cnt, last_pkt_toggles;

    logic          s_ready, s_stat_valid;
    logic [3:0]    s_flit_cnt, s_pkt_cnt, s_len_err_cnt, s_idle_cnt, s_toggle_cnt, s_last_pkt_toggles;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint        m_flit, m_pkt, m_err, m_idle, m_tog, m_lpt, m_plen, m_ptog;
    bit            m_win, m_sv;
    logic [FW-1:0] m_prev;

    always #5 clk = ~clk;

    flit_activity_sink #(.N(N), .PAYLOAD(PL), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flit_valid(flit_valid), .flit_data(flit_data),
        .flit_last(flit_last), .flit_ready(flit_ready), .sink_stall(sink_stall),
        .meas_start(meas_start), .meas_stop(meas_stop), .stat_valid(stat_valid),
        .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt), .len_err_cnt(len_err_cnt),
        .idle_cnt(idle_cnt), .toggle_cnt(toggle_cnt), .last_pkt_toggles(last_pkt_toggles)
    );

    flit_activity_sink #(.N(N), .PAYLOAD(PL), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .flit_valid(flit_valid), .flit_data(flit_data),
        .flit_last(flit_last), .flit_ready(s_ready), .sink_stall(sink_stall),
        .meas_start(meas_start), .meas_stop(meas_stop), .stat_valid(s_stat_valid),
        .flit_cnt(s_flit_cnt), .pkt_cnt(s_pkt_cnt), .len_err_cnt(s_len_err_cnt),
        .idle_cnt(s_idle_cnt), .toggle_cnt(s_toggle_cnt), .last_pkt_toggles(s_last_pkt_toggles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flit = 0; m_pkt = 0; m_err = 0; m_idle = 0; m_tog = 0; m_lpt = 0;
        m_plen = 0; m_ptog = 0; m_win = 0; m_sv = 0; m_prev = '0;
    endtask

    // One cycle of the accounting rules applied to the inputs just clocked in.
    task automatic model_step(input logic v, input logic [FW-1:0] d, input logic l,
                              input logic st, input logic s0, input logic s1);
        bit     acc;
        longint t;
        acc = v && !st;
        t   = longint'($countones(d ^ m_prev));
        if (m_win) begin
            if (acc) begin
                m_flit++;
                m_tog  += t;
                m_plen++;
                m_ptog += t;
                if (l) begin
                    m_pkt++;
                    m_lpt = m_ptog;
                    if (m_plen != PL) m_err++;
                    m_plen = 0;
                    m_ptog = 0;
                end
            end else begin
                m_idle++;
            end
        end
        if (acc) m_prev = d;
        if (!m_win && s0) begin
            m_flit = 0; m_pkt = 0; m_err = 0; m_idle = 0; m_tog = 0; m_lpt = 0;
            m_plen = 0; m_ptog = 0; m_win = 1; m_sv = 0;
        end else if (m_win && s1) begin
            m_win = 0;
            m_sv  = 1;
        end
    endtask

    task automatic check_all();
        chk("stat_valid", {31'd0, stat_valid}, {31'd0, m_sv});
        chk("flit_cnt", flit_cnt, 32'(m_flit));
        chk("pkt_cnt", pkt_cnt, 32'(m_pkt));
        chk("len_err_cnt", len_err_cnt, 32'(m_err));
        chk("idle_cnt", idle_cnt, 32'(m_idle));
        chk("toggle_cnt", toggle_cnt, 32'(m_tog));
        chk("last_pkt_toggles", last_pkt_toggles, 32'(m_lpt));
    endtask

    // Called one time unit after a rising edge; drives one cycle and checks after the next edge.
    task automatic cyc(input logic v, input logic [FW-1:0] d, input logic l,
                       input logic st, input logic s0, input logic s1);
        logic rdy_exp;
        flit_valid = v; flit_data = d; flit_last = l;
        sink_stall = st; meas_start = s0; meas_stop = s1;
        rdy_exp = ~st;
        #1;
        chk("flit_ready", {31'd0, flit_ready}, {31'd0, rdy_exp});
        @(posedge clk);
        #1;
        model_step(v, d, l, st, s0, s1);
        check_all();
    endtask

    task automatic idle_cyc(input logic s0, input logic s1);
        cyc(1'b0, '0, 1'b0, 1'b0, s0, s1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flit_valid = 1'b0; flit_data = '0; flit_last = 1'b0;
        sink_stall = 1'b0; meas_start = 1'b0; meas_stop = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-window with traffic running, then traffic with no window open
        idle_cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, FW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        flit_valid = 1'b1; flit_data = FW'($urandom);
        do_reset();
        chk("reset_flit_cnt", flit_cnt, 32'd0);
        chk("reset_stat_valid", {31'd0, stat_valid}, 32'd0);
        cyc(1'b1, FW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_state_no_count", flit_cnt, 32'd0);
        do_reset();

        // Toggle counting from a freshly reset previous flit
        idle_cyc(1'b1, 1'b0);
        cyc(1'b1, 26'h3FFF000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 26'h0FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cyc(1'b0, 1'b1);
        chk("tog_toggle_cnt", toggle_cnt, 32'd28);
        chk("tog_last_pkt", last_pkt_toggles, 32'd28);
        chk("tog_pkt_cnt", pkt_cnt, 32'd1);
        chk("tog_len_err", len_err_cnt, 32'd1);
        chk("tog_stat_valid", {31'd0, stat_valid}, 32'd1);

        // Full run: 10 packets of 20 flits, 7-cycle gaps, stop right after the last tail
        idle_cyc(1'b1, 1'b0);
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 20; f++)
                cyc(1'b1, FW'($urandom), (f == 19), 1'b0, 1'b0, 1'b0);
            if (p < 9) for (int g = 0; g < 7; g++) idle_cyc(1'b0, 1'b0);
        end
        idle_cyc(1'b0, 1'b1);
        chk("run_flit_cnt", flit_cnt, 32'd200);
        chk("run_pkt_cnt", pkt_cnt, 32'd10);
        chk("run_len_err", len_err_cnt, 32'd0);
        chk("run_idle_cnt", idle_cnt, 32'd64);
        chk("run_stat_valid", {31'd0, stat_valid}, 32'd1);

        // Backpressure: 3 stalled cycles in the middle of a packet
        begin
            logic [FW-1:0] held;
            idle_cyc(1'b1, 1'b0);
            for (int f = 0; f < 10; f++) cyc(1'b1, FW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            held = FW'($urandom);
            for (int s = 0; s < 3; s++) begin
                cyc(1'b1, held, 1'b0, 1'b1, 1'b0, 1'b0);
                chk("stall_flit_cnt", flit_cnt, 32'd10);
            end
            cyc(1'b1, held, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int f = 11; f < 20; f++) cyc(1'b1, FW'($urandom), (f == 19), 1'b0, 1'b0, 1'b0);
            idle_cyc(1'b0, 1'b1);
            chk("bp_flit_cnt", flit_cnt, 32'd20);
            chk("bp_pkt_cnt", pkt_cnt, 32'd1);
            chk("bp_len_err", len_err_cnt, 32'd0);
            chk("bp_idle_cnt", idle_cnt, 32'd4);
        end

        // Stop inside a packet, then simultaneous start+stop from DONE
        idle_cyc(1'b1, 1'b0);
        for (int f = 0; f < 5; f++) cyc(1'b1, FW'($urandom), 1'b0, 1'b0, 1'b0, (f == 4));
        chk("partial_stat_valid", {31'd0, stat_valid}, 32'd1);
        chk("partial_flit_cnt", flit_cnt, 32'd5);
        chk("partial_pkt_cnt", pkt_cnt, 32'd0);
        idle_cyc(1'b1, 1'b1);
        chk("restart_stat_valid", {31'd0, stat_valid}, 32'd0);
        chk("restart_flit_cnt", flit_cnt, 32'd0);
        idle_cyc(1'b0, 1'b0);
        chk("restart_idle_cnt", idle_cnt, 32'd1);
        for (int f = 0; f < 20; f++) cyc(1'b1, FW'($urandom), (f == 19), 1'b0, 1'b0, 1'b0);
        idle_cyc(1'b0, 1'b1);
        chk("restart_len_err", len_err_cnt, 32'd0);
        chk("restart_pkt_cnt", pkt_cnt, 32'd1);

        // Saturation on the 4-bit instance
        do_reset();
        idle_cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) idle_cyc(1'b0, 1'b0);
        chk("sat_idle_cnt", {28'd0, s_idle_cnt}, 32'd15);
        for (int i = 0; i < 3; i++) cyc(1'b1, ~m_prev, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_toggle_cnt", {28'd0, s_toggle_cnt}, 32'd15);
        chk("sat_flit_cnt", {28'd0, s_flit_cnt}, 32'd3);
        idle_cyc(1'b0, 1'b1);

        // Random traffic with random window control
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), FW'($urandom), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 60) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
